// File: rtl/display_ctrl.sv
// display_ctrl: registered LED/7-segment driver with freeze, leading-zero blanking and blinking done LED
module display_ctrl #(
    parameter int DATA_W    = 10,
    parameter int TIME_W    = 2,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [DATA_W-1:0]              BUS,
    input  logic [DATA_W-1:0]              REG,
    input  logic [TIME_W-1:0]              TIME,
    input  logic                           PEEKb,
    input  logic                           DONE,
    input  logic                           HOLD,
    input  logic                           BLANK_LZ,
    output logic [DATA_W-1:0]              LED_B,
    output logic [7*((DATA_W+3)/4)-1:0]    DHEX,
    output logic [6:0]                     THEX,
    output logic                           LED_D,
    output logic                           LED_H
);
    localparam int NDIG = (DATA_W + 3) / 4;
    localparam int NW   = 4 * NDIG;
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    if (TIME_W < 1 || TIME_W > 4) begin : g_bad_time_w
        $error("display_ctrl: TIME_W must be 1..4");
    end

    typedef enum logic {LIVE, FROZEN} state_t;

    state_t              state, state_nx;
    logic                hold_q, hold_rise;
    logic [DATA_W-1:0]   sel, cap, cap_nx;
    logic [NW-1:0]       ext;
    logic                seen;
    logic [7*NDIG-1:0]   dhex_nx;

    // source select, freeze toggle on HOLD rising edge, capture holds while frozen
    always_comb begin
        sel       = PEEKb ? BUS : REG;
        hold_rise = HOLD & ~hold_q;
        state_nx  = hold_rise ? (state == LIVE ? FROZEN : LIVE) : state;
        cap_nx    = state == LIVE ? sel : cap;
    end

    // encode digits from the top down so blanking stops at the first nonzero nibble
    always_comb begin
        ext     = NW'(cap_nx);
        seen    = 1'b0;
        dhex_nx = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            seen = seen | (ext[4*i +: 4] != 4'h0) | (i == 0);
            dhex_nx[7*i +: 7] = (BLANK_LZ && !seen) ? 7'h7F : SEG[ext[4*i +: 4]];
        end
    end

    // state, capture and all display registers except the done LED
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= LIVE;
            hold_q <= 1'b0;
            cap    <= '0;
            LED_B  <= '0;
            DHEX   <= {NDIG{7'h40}};
            THEX   <= 7'h40;
            LED_H  <= 1'b0;
        end else begin
            state  <= state_nx;
            hold_q <= HOLD;
            cap    <= cap_nx;
            LED_B  <= BUS;
            DHEX   <= dhex_nx;
            THEX   <= SEG[4'(TIME)];
            LED_H  <= state_nx == FROZEN;
        end
    end

    if (BLINK_DIV == 0) begin : g_solid
        // solid done LED follows DONE one edge later
        always_ff @(posedge CLK) begin
            LED_D <= RST ? 1'b0 : DONE;
        end
    end else begin : g_blink
        localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
        logic [CW-1:0] cnt;
        logic          phase, done_q;
        // half-period counter; a DONE rising edge restarts the blink with the LED lit
        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt    <= '0;
                phase  <= 1'b0;
                done_q <= 1'b0;
                LED_D  <= 1'b0;
            end else begin
                done_q <= DONE;
                if (!DONE) begin
                    cnt   <= '0;
                    LED_D <= 1'b0;
                end else if (!done_q) begin
                    cnt   <= '0;
                    phase <= 1'b1;
                    LED_D <= 1'b1;
                end else if (cnt == CW'(BLINK_DIV - 1)) begin
                    cnt   <= '0;
                    phase <= ~phase;
                    LED_D <= ~phase;
                end else begin
                    cnt   <= cnt + CW'(1);
                    LED_D <= phase;
                end
            end
        end
    end
endmodule

// File: tb/tb_display_ctrl.sv
// tb_display_ctrl: directed checks of display_ctrl in two parameter configurations
module tb_display_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, peek, done, hold, blz;
    logic [9:0]  bus, rg;
    logic [1:0]  tm;
    logic [9:0]  led_b;
    logic [20:0] dhex;
    logic [6:0]  thex;
    logic        led_d, led_h;

    logic        peek2, done2, hold2, blz2;
    logic [15:0] bus2, rg2;
    logic [3:0]  tm2;
    logic [15:0] led_b2;
    logic [27:0] dhex2;
    logic [6:0]  thex2;
    logic        led_d2, led_h2;

    int errors = 0;
    int checks = 0;

    display_ctrl #(.DATA_W(10), .TIME_W(2), .BLINK_DIV(4)) dut (
        .CLK(clk), .RST(rst), .BUS(bus), .REG(rg), .TIME(tm), .PEEKb(peek),
        .DONE(done), .HOLD(hold), .BLANK_LZ(blz), .LED_B(led_b), .DHEX(dhex),
        .THEX(thex), .LED_D(led_d), .LED_H(led_h)
    );

    display_ctrl #(.DATA_W(16), .TIME_W(4), .BLINK_DIV(0)) dut2 (
        .CLK(clk), .RST(rst), .BUS(bus2), .REG(rg2), .TIME(tm2), .PEEKb(peek2),
        .DONE(done2), .HOLD(hold2), .BLANK_LZ(blz2), .LED_B(led_b2), .DHEX(dhex2),
        .THEX(thex2), .LED_D(led_d2), .LED_H(led_h2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [6:0] seg_t [4] = '{7'h40, 7'h79, 7'h24, 7'h30};

    initial begin
        rst = 1; peek = 0; done = 0; hold = 0; blz = 0; bus = '0; rg = '0; tm = '0;
        peek2 = 0; done2 = 0; hold2 = 0; blz2 = 0; bus2 = '0; rg2 = 16'hBEEF; tm2 = 4'hC;
        step();
        step();
        chk("rst_dhex", dhex, {7'h40, 7'h40, 7'h40});
        chk("rst_thex", thex, 7'h40);
        chk("rst_led_d", led_d, 1'b0);
        chk("rst_led_h", led_h, 1'b0);
        chk("rst_led_b", led_b, 10'h0);
        chk("rst_dhex16", dhex2, {4{7'h40}});

        rst = 0; bus = 10'h2A5; peek = 1;
        step();
        chk("bus_dhex", dhex, {7'h24, 7'h08, 7'h12});
        chk("bus_led_b", led_b, 10'h2A5);
        chk("w16_dhex", dhex2, {7'h03, 7'h06, 7'h06, 7'h0E});
        chk("w16_thex", thex2, 7'h46);

        peek = 0; rg = 10'h0F3;
        step();
        chk("reg_dhex", dhex, {7'h40, 7'h0E, 7'h30});

        bus = 10'h155; peek = 1; hold = 1;
        step();
        chk("frz_led_h", led_h, 1'b1);
        chk("frz_dhex", dhex, {7'h79, 7'h12, 7'h12});
        hold = 0; bus = 10'h3FF; peek = 0;
        step();
        chk("frz_hold_dhex", dhex, {7'h79, 7'h12, 7'h12});
        chk("frz_led_b", led_b, 10'h3FF);
        peek = 1;
        step();
        chk("frz_peek_dhex", dhex, {7'h79, 7'h12, 7'h12});
        chk("frz_still_h", led_h, 1'b1);

        hold = 1;
        step();
        chk("unfrz_led_h", led_h, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("held_led_h", led_h, 1'b0);
        chk("live_dhex", dhex, {7'h30, 7'h0E, 7'h0E});
        hold = 0;
        step();
        hold = 1;
        step();
        chk("refrz_led_h", led_h, 1'b1);
        hold = 0; bus = 10'h001;
        step();
        chk("refrz_dhex", dhex, {7'h30, 7'h0E, 7'h0E});
        hold = 1;
        step();
        hold = 0;
        step();
        chk("relive_dhex", dhex, {7'h40, 7'h40, 7'h79});
        chk("relive_led_h", led_h, 1'b0);

        blz = 1; peek = 0; rg = 10'h007;
        step();
        chk("blz_007", dhex, {7'h7F, 7'h7F, 7'h78});
        rg = 10'h000;
        step();
        chk("blz_000", dhex, {7'h7F, 7'h7F, 7'h40});
        rg = 10'h100;
        step();
        chk("blz_100", dhex, {7'h79, 7'h40, 7'h40});
        rg = 10'h0A0;
        step();
        chk("blz_0a0", dhex, {7'h7F, 7'h08, 7'h40});
        blz = 0;
        step();
        chk("noblz_0a0", dhex, {7'h40, 7'h08, 7'h40});

        for (int t = 0; t < 4; t++) begin
            tm = 2'(t);
            step();
            chk($sformatf("thex_%0d", t), thex, seg_t[t]);
        end

        done = 1; done2 = 1;
        step();
        chk("blink_rise", led_d, 1'b1);
        chk("solid_on", led_d2, 1'b1);
        for (int i = 1; i < 12; i++) begin
            step();
            chk($sformatf("blink_%0d", i), led_d, ((i / 4) % 2) == 0);
        end
        done = 0; done2 = 0;
        step();
        chk("blink_fall", led_d, 1'b0);
        chk("solid_off", led_d2, 1'b0);
        done = 1;
        step();
        chk("blink_rerise", led_d, 1'b1);

        hold = 1;
        step();
        hold = 0;
        step();
        chk("pre_rst_h", led_h, 1'b1);
        rst = 1; hold = 1;
        step();
        chk("rstp_led_h", led_h, 1'b0);
        chk("rstp_dhex", dhex, {7'h40, 7'h40, 7'h40});
        chk("rstp_led_d", led_d, 1'b0);
        chk("rstp_led_b", led_b, 10'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
